// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache request arbiter
package cache_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 10;
    localparam int IDX_W  = 5;
    localparam int OFF_W  = 4;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_READ8    = 3'd1,
        CMD_READ16   = 3'd2,
        CMD_READ32   = 3'd3,
        CMD_INV_LINE = 3'd4,
        CMD_WRITE8   = 3'd5,
        CMD_WRITE16  = 3'd6,
        CMD_WRITE32  = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    function automatic logic is_read(cmd_e c);
        return (c == CMD_READ8) || (c == CMD_READ16) || (c == CMD_READ32);
    endfunction

endpackage

// File: rtl/cache_req_arbiter_if.sv
// rtl/cache_req_arbiter_if.sv - command/response bus between the arbiter and the cache
interface cache_req_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 32
);
    logic              cache_cmd_valid;
    logic [2:0]        cache_cmd;
    logic [ADDR_W-1:0] cache_addr;
    logic [DATA_W-1:0] cache_wdata;
    logic              cache_done;
    logic [DATA_W-1:0] cache_rdata;

    modport master (
        output cache_cmd_valid, cache_cmd, cache_addr, cache_wdata,
        input  cache_done, cache_rdata
    );

    modport slave (
        input  cache_cmd_valid, cache_cmd, cache_addr, cache_wdata,
        output cache_done, cache_rdata
    );
endinterface

// File: rtl/cache_req_arbiter_rr_pick2.sv
// rtl/cache_req_arbiter_rr_pick2.sv - combinational two-way round-robin selector
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_valid,
    output logic       gnt_idx
);
    // ptr only matters under contention; a lone requester always wins
    assign gnt_valid = |req;
    assign gnt_idx   = (req == 2'b11) ? ptr : req[1];
endmodule

// File: rtl/cache_req_arbiter.sv
// rtl/cache_req_arbiter.sv - shares the cache command port between two requesters
module cache_req_arbiter #(
    parameter int ADDR_W  = cache_pkg::ADDR_W,
    parameter int DATA_W  = cache_pkg::DATA_W,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [2:0]        cmd0,
    input  logic [2:0]        cmd1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    cache_req_arbiter_if.master cache,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);
    import cache_pkg::*;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    arb_state_e        state, state_nxt;
    logic              ptr;
    logic              gnt_valid, gnt_idx;
    logic              g_lat;
    cmd_e              cmd_lat, sel_cmd;
    logic [ADDR_W-1:0] addr_lat, sel_addr;
    logic [DATA_W-1:0] wdata_lat, sel_wdata;
    logic [DATA_W-1:0] rdata_lat;
    logic              err_lat;
    logic [7:0]        tmo_cnt;
    logic              tmo_hit;
    logic              grant;

    rr_pick2 u_pick (
        .req       (req),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign sel_cmd   = cmd_e'(gnt_idx ? cmd1 : cmd0);
    assign sel_addr  = gnt_idx ? addr1 : addr0;
    assign sel_wdata = gnt_idx ? wdata1 : wdata0;
    assign grant     = (state == IDLE) && gnt_valid;
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (gnt_valid) state_nxt = (sel_cmd == CMD_NOP) ? RESP : ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (cache.cache_done || tmo_hit) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done                  = 2'b00;
        err                   = 1'b0;
        rdata                 = '0;
        cache.cache_cmd_valid = 1'b0;
        cache.cache_cmd       = 3'd0;
        cache.cache_addr      = '0;
        cache.cache_wdata     = '0;
        if (state == ISSUE || state == WAIT) begin
            cache.cache_cmd_valid = (state == ISSUE);
            cache.cache_cmd       = cmd_lat;
            cache.cache_addr      = addr_lat;
            cache.cache_wdata     = wdata_lat;
        end
        if (state == RESP) begin
            done  = g_lat ? 2'b10 : 2'b01;
            err   = err_lat;
            rdata = rdata_lat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 1'b0;
            g_lat     <= 1'b0;
            cmd_lat   <= CMD_NOP;
            addr_lat  <= '0;
            wdata_lat <= '0;
            rdata_lat <= '0;
            err_lat   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        g_lat     <= gnt_idx;
                        cmd_lat   <= sel_cmd;
                        addr_lat  <= sel_addr;
                        wdata_lat <= sel_wdata;
                        rdata_lat <= '0;
                        err_lat   <= 1'b0;
                    end
                end
                ISSUE: tmo_cnt <= '0;
                WAIT: begin
                    // non-read commands never return data, even if the cache drives some
                    if (cache.cache_done) begin
                        rdata_lat <= is_read(cmd_lat) ? cache.cache_rdata : '0;
                        err_lat   <= 1'b0;
                    end else if (tmo_hit) begin
                        rdata_lat <= '0;
                        err_lat   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RESP: ptr <= ~g_lat;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (grant) begin
            if (!gnt_idx && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (gnt_idx && grant_cnt1 != '1)  grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb/tb_cache_req_arbiter.sv - self-checking bench for cache_req_arbiter
module tb_cache_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req;
    logic [2:0]  cmd0, cmd1;
    logic [18:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  done;
    logic        err;
    logic [31:0] rdata;
    logic [1:0]  grant_cnt0, grant_cnt1;

    always #5 clk = ~clk;

    cache_req_arbiter_if #(.ADDR_W(19), .DATA_W(32)) cif ();

    cache_req_arbiter #(
        .ADDR_W(19), .DATA_W(32), .TIMEOUT(8), .CNT_W(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .cmd0       (cmd0),
        .cmd1       (cmd1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .cache      (cif),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    typedef struct {
        logic [1:0]  req;
        logic [2:0]  cmd0, cmd1;
        logic [18:0] addr0, addr1;
        logic [31:0] wdata0, wdata1;
        int          lat;
        logic [31:0] resp;
        logic [1:0]  e_done;
        logic [31:0] e_rdata;
        int          e_k;
        int          e_nvalid;
        logic [2:0]  e_ccmd;
        logic [18:0] e_caddr;
        logic [31:0] e_cwdata;
        logic [1:0]  e_cnt0, e_cnt1;
    } vec_t;

    vec_t        vecs [8];
    int          n_vec = 0;
    int          n_bad = 0;
    bit          cache_en;
    int          cache_lat;
    int          pend;
    logic [31:0] cache_resp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // one clock, then the cache model answers cache_lat cycles after each strobe
    task automatic tick();
        @(posedge clk);
        #1;
        cif.cache_done = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                cif.cache_done  = 1'b1;
                cif.cache_rdata = cache_resp;
            end
        end
        if (cache_en && cif.cache_cmd_valid) pend = cache_lat;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 2'b00; cmd0 = 3'd0; cmd1 = 3'd0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        pend = 0; cache_en = 1'b0; cache_lat = 1; cache_resp = '0;
        cif.cache_done = 1'b0; cif.cache_rdata = '0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int  nvalid;
        bit  got;
        req = v.req; cmd0 = v.cmd0; cmd1 = v.cmd1;
        addr0 = v.addr0; addr1 = v.addr1; wdata0 = v.wdata0; wdata1 = v.wdata1;
        cache_en = 1'b1; cache_lat = v.lat; cache_resp = v.resp;
        nvalid = 0; got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            tick();
            if (cif.cache_cmd_valid) begin
                nvalid++;
                chk($sformatf("v%0d_ccmd", idx), 64'(cif.cache_cmd), 64'(v.e_ccmd));
                chk($sformatf("v%0d_caddr", idx), 64'(cif.cache_addr), 64'(v.e_caddr));
                chk($sformatf("v%0d_cwdata", idx), 64'(cif.cache_wdata), 64'(v.e_cwdata));
            end
            if (done != 2'b00) begin
                got = 1'b1;
                chk($sformatf("v%0d_done", idx), 64'(done), 64'(v.e_done));
                chk($sformatf("v%0d_rdata", idx), 64'(rdata), 64'(v.e_rdata));
                chk($sformatf("v%0d_err", idx), 64'(err), 64'(0));
                chk($sformatf("v%0d_latency", idx), 64'(k), 64'(v.e_k));
                chk($sformatf("v%0d_cnt0", idx), 64'(grant_cnt0), 64'(v.e_cnt0));
                chk($sformatf("v%0d_cnt1", idx), 64'(grant_cnt1), 64'(v.e_cnt1));
                req = 2'b00;
            end
        end
        chk($sformatf("v%0d_done_seen", idx), 64'(got), 64'(1));
        chk($sformatf("v%0d_nvalid", idx), 64'(nvalid), 64'(v.e_nvalid));
        req = 2'b00;
        tick();
    endtask

    initial begin
        int  nd;
        int  nvalid;
        int  tk;
        bit  any_done;
        bit  any_valid;

        //          req    cmd0  cmd1  addr0        addr1        wdata0        wdata1        lat resp          e_done e_rdata       k  nv ccmd  caddr        cwdata        c0    c1
        vecs[0] = '{2'b01, 3'd3, 3'd0, 19'h2_0008, 19'h0_0000, 32'h0,        32'h0,        4, 32'hDEADBEEF, 2'b01, 32'hDEADBEEF, 6, 1, 3'd3, 19'h2_0008, 32'h0,        2'd1, 2'd0};
        vecs[1] = '{2'b10, 3'd0, 3'd7, 19'h0_0000, 19'h2_0C08, 32'h0,        32'h8C1F7FFF, 2, 32'h12345678, 2'b10, 32'h0,        4, 1, 3'd7, 19'h2_0C08, 32'h8C1F7FFF, 2'd1, 2'd1};
        vecs[2] = '{2'b11, 3'd1, 3'd2, 19'h0_0010, 19'h7_FFFF, 32'h11111111, 32'h22222222, 1, 32'hA5A5A5A5, 2'b01, 32'hA5A5A5A5, 3, 1, 3'd1, 19'h0_0010, 32'h11111111, 2'd2, 2'd1};
        vecs[3] = '{2'b11, 3'd1, 3'd2, 19'h0_0010, 19'h7_FFFF, 32'h11111111, 32'h22222222, 3, 32'h0000BEEF, 2'b10, 32'h0000BEEF, 5, 1, 3'd2, 19'h7_FFFF, 32'h22222222, 2'd2, 2'd2};
        vecs[4] = '{2'b01, 3'd0, 3'd3, 19'h1_5555, 19'h0_0000, 32'h0,        32'h0,        1, 32'hCAFEF00D, 2'b01, 32'h0,        1, 0, 3'd0, 19'h0_0000, 32'h0,        2'd3, 2'd2};
        vecs[5] = '{2'b10, 3'd0, 3'd4, 19'h0_0000, 19'h1_2340, 32'h0,        32'h55AA55AA, 1, 32'hFFFFFFFF, 2'b10, 32'h0,        3, 1, 3'd4, 19'h1_2340, 32'h55AA55AA, 2'd3, 2'd3};
        vecs[6] = '{2'b11, 3'd5, 3'd3, 19'h0_00FF, 19'h4_4444, 32'h000000AB, 32'h0,        2, 32'h99999999, 2'b01, 32'h0,        4, 1, 3'd5, 19'h0_00FF, 32'h000000AB, 2'd3, 2'd3};
        vecs[7] = '{2'b11, 3'd5, 3'd3, 19'h0_00FF, 19'h4_4444, 32'h000000AB, 32'h0,        5, 32'h13572468, 2'b10, 32'h13572468, 7, 1, 3'd3, 19'h4_4444, 32'h0,        2'd3, 2'd3};

        do_reset();
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_cvalid", 64'(cif.cache_cmd_valid), 64'(0));
        chk("rst_caddr", 64'(cif.cache_addr), 64'(0));
        chk("rst_cnt0", 64'(grant_cnt0), 64'(0));
        chk("rst_cnt1", 64'(grant_cnt1), 64'(0));

        for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

        // contention: both ports hold req, grants must alternate
        do_reset();
        cache_en = 1'b1; cache_lat = 1; cache_resp = 32'h0BADF00D;
        req = 2'b11; cmd0 = 3'd3; cmd1 = 3'd3; addr0 = 19'h0_0100; addr1 = 19'h0_0200;
        nd = 0; nvalid = 0;
        for (int k = 0; k < 40 && nd < 4; k++) begin
            tick();
            if (cif.cache_cmd_valid) nvalid++;
            if (done != 2'b00) begin
                chk($sformatf("rr_order%0d", nd), 64'(done), 64'((nd % 2 == 0) ? 2'b01 : 2'b10));
                nd++;
                if (nd == 4) req = 2'b00;
            end
        end
        tick();
        chk("rr_ntxn", 64'(nd), 64'(4));
        chk("rr_nvalid", 64'(nvalid), 64'(4));
        chk("rr_cnt0", 64'(grant_cnt0), 64'(2));
        chk("rr_cnt1", 64'(grant_cnt1), 64'(2));

        // timeout with a silent cache, then a late response
        do_reset();
        req = 2'b10; cmd1 = 3'd3; addr1 = 19'h3_0000;
        tk = 0;
        for (int k = 1; k <= 30 && tk == 0; k++) begin
            tick();
            if (done != 2'b00) begin
                tk = k;
                chk("tmo_done", 64'(done), 64'(2'b10));
                chk("tmo_err", 64'(err), 64'(1));
                chk("tmo_rdata", 64'(rdata), 64'(0));
                req = 2'b00;
            end
        end
        chk("tmo_latency", 64'(tk), 64'(10));
        tick();
        cif.cache_done = 1'b1; cif.cache_rdata = 32'hFEEDFACE;
        any_done = 1'b0; any_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            any_done  |= (done != 2'b00) || err;
            any_valid |= cif.cache_cmd_valid;
        end
        chk("late_done", 64'(any_done), 64'(0));
        chk("late_valid", 64'(any_valid), 64'(0));
        chk("late_cnt1", 64'(grant_cnt1), 64'(1));

        // reset in the middle of WAIT
        do_reset();
        req = 2'b01; cmd0 = 3'd3; addr0 = 19'h1_1111;
        tick(); tick(); tick();
        chk("mid_caddr_pre", 64'(cif.cache_addr), 64'(19'h1_1111));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_caddr", 64'(cif.cache_addr), 64'(0));
        chk("mid_ccmd", 64'(cif.cache_cmd), 64'(0));
        chk("mid_done", 64'(done), 64'(0));
        chk("mid_cnt0", 64'(grant_cnt0), 64'(0));
        req = 2'b00;
        tick();
        rst_n = 1'b1;
        cif.cache_done = 1'b1; cif.cache_rdata = 32'h77777777;
        any_done = 1'b0; any_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            any_done  |= (done != 2'b00);
            any_valid |= cif.cache_cmd_valid;
        end
        chk("post_rst_done", 64'(any_done), 64'(0));
        chk("post_rst_valid", 64'(any_valid), 64'(0));

        // counter saturation via back-to-back NOPs on port 0
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            req = 2'b01; cmd0 = 3'd0;
            tick();
            chk($sformatf("sat%0d_done", i), 64'(done), 64'(2'b01));
            chk($sformatf("sat%0d_cvalid", i), 64'(cif.cache_cmd_valid), 64'(0));
            chk($sformatf("sat%0d_cnt0", i), 64'(grant_cnt0), 64'((i > 3) ? 3 : i));
            req = 2'b00;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
- Shares the single CPU-side command port of the cache between two requesters, port 0 and port 1.
- Selects requesters round-robin, latches the winner's command, issues it to the cache as a one-cycle strobe, waits for the cache's done pulse with a timeout, and returns read data to the winner.
- Keeps saturating per-port grant counters for performance reporting.
- Sits between the CPU-side masters and the cache.

Parameters:
- ADDR_W, 19, address width: tag 10, index 5, offset 4 bits.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum WAIT cycles before an error completion; range 1..255.
- CNT_W, 16, width of each grant counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  2  per-port request; held high until that port's done.
- cmd0, cmd1  in  3  per-port command code from cache_pkg.
- addr0, addr1  in  ADDR_W  per-port byte address.
- wdata0, wdata1  in  DATA_W  per-port write data.
- done  out  2  one-hot, one-cycle completion pulse.
- err  out  1  valid with done: 1 means the access timed out.
- rdata  out  DATA_W  valid with done.
- cache_cmd_valid  out  1  one-cycle command strobe to the cache.
- cache_cmd  out  3  command to the cache.
- cache_addr  out  ADDR_W  address to the cache.
- cache_wdata  out  DATA_W  write data to the cache.
- cache_done  in  1  one-cycle completion pulse from the cache.
- cache_rdata  in  DATA_W  cache read data, valid with cache_done.
- grant_cnt0, grant_cnt1  out  CNT_W  saturating grant counts.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; round-robin pointer = port 0 preferred.
  - All outputs 0, including both grant counters.
  - Release is synchronous to clk.
- Command codes: 0 NOP, 1 READ8, 2 READ16, 3 READ32, 4 INVALIDATE_LINE, 5 WRITE8, 6 WRITE16, 7 WRITE32.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that port.
  - Both req: grant the port named by the pointer.
  - On grant, latch cmd/addr/wdata of the winner and increment its grant counter (saturate at all-ones).
  - NOP goes to RESP; any other command goes to ISSUE.
- ISSUE (1 cycle):
  - cache_cmd_valid=1; cache_cmd/addr/wdata driven from the latch.
  - Clear the timeout counter; go to WAIT.
  - cache_cmd/addr/wdata stay driven from the latch through WAIT; cache_cmd_valid=0 outside ISSUE.
- WAIT:
  - cache_done=1: latch cache_rdata, err_next=0, go to RESP.
  - Timeout counter reaching TIMEOUT without cache_done: rdata_next=0, err_next=1, go to RESP.
  - Otherwise increment the counter and stay in WAIT.
- RESP (1 cycle):
  - done[g]=1 for the granted port g only; rdata and err driven from the latch.
  - rdata=0 for NOP, INVALIDATE_LINE, and all writes.
  - Pointer set to the other port (1-g); go to IDLE.
  - Outside RESP: done=0, err=0, rdata=0.
- Requester rule:
  - req must be low in the cycle after done.
  - A req still high then is treated as a new request and re-arbitrated.
- Latency: a cache access is 2 cycles plus cache latency from grant to done; a NOP is done 1 cycle after grant.
- cache_done outside WAIT (stray, or a late response after timeout) is ignored and has no effect on state.
- Changes on req/cmd inputs after grant have no effect until the next IDLE.
- Reset mid-operation: return to IDLE immediately; no done is generated; a pending cache_done after reset is ignored.

Decomposition:
- cache_pkg holds:
  - the cmd_e enum (3-bit codes above);
  - ADDR_W, DATA_W, and the TAG_W=10 / IDX_W=5 / OFF_W=4 address-split constants;
  - the arb_state_e enum {IDLE, ISSUE, WAIT, RESP}.
- One sub-module, rr_pick2: combinational 2-way round-robin selector with inputs req[1:0] and ptr, outputs gnt_valid and gnt_idx.
- The FSM, latches, timeout counter and grant counters stay in the top module.

Test Plan:
- Single read on port 0:
  - Stimulus: req=01, cmd0=READ32, addr0=19'h2_0008; cache_done 4 cycles after the ISSUE strobe with cache_rdata=32'hDEADBEEF.
  - Response: done=01 exactly one cycle after cache_done, rdata=32'hDEADBEEF, err=0, grant_cnt0=1.
- Contention:
  - Stimulus: req=11 held; each port re-requests immediately after its done.
  - Response: grants alternate 0,1,0,1; after 4 transactions grant_cnt0=2 and grant_cnt1=2; exactly one cache_cmd_valid per transaction.
- Write then read:
  - Stimulus: port 1 WRITE32 to 19'h2_0C08 with wdata=32'h8C1F7FFF.
  - Response: the cache sees cmd=7 with that address and data in the ISSUE cycle; done=10 with rdata=0.
- Timeout:
  - Stimulus: TIMEOUT=8; cache_done never asserted.
  - Response: done pulses 10 cycles after grant (ISSUE + 8 WAIT + RESP) with err=1 and rdata=0; a late cache_done afterwards changes nothing.
- NOP and reset:
  - NOP on port 0 gives done=01 one cycle after grant, with no cache_cmd_valid.
  - Asserting rst_n=0 during WAIT clears all outputs asynchronously; no done follows.
- Counter saturation: with CNT_W=2, after 5 grants to port 0, grant_cnt0 holds at 3.
